// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction ROM arbiter and its two requesters plus the ROM.
// The arbiter takes the slave modport; the requester/ROM side takes master.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err, mem_addr
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter (fetch priority, bounded DBG starvation) in front of a combinational ROM.
// Optional performance counters are enabled with `define IMEM_ARB_PERF_EN.
module imem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int STREAK_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IMEM_ARB_PERF_EN
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_dbg_cnt,
    output logic [31:0] perf_force_cnt,
`endif
    imem_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        PRI_IF    = 1'b0,
        FORCE_DBG = 1'b1
    } state_e;

    localparam logic [STREAK_W-1:0] MAX_S     = STREAK_W'(MAX_STREAK);
    localparam logic [ADDR_W-1:0]   WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_gnt, dbg_gnt;
    logic [ADDR_W-1:0]   granted_addr;

    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              dbg_err_q, dbg_err_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        if_gnt   = 1'b0;
        dbg_gnt  = 1'b0;
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            PRI_IF: begin
                if (bus.if_req) begin
                    if_gnt = 1'b1;
                end else if (bus.dbg_req) begin
                    dbg_gnt = 1'b1;
                end
                if (if_gnt && bus.dbg_req) begin
                    streak_d = streak_q + 1'b1;
                    if (streak_d == MAX_S) begin
                        state_d = FORCE_DBG;
                    end
                end else begin
                    streak_d = '0;
                end
            end
            FORCE_DBG: begin
                // DBG owns this slot; IF only gets it if DBG has gone away.
                if (bus.dbg_req) begin
                    dbg_gnt = 1'b1;
                end else if (bus.if_req) begin
                    if_gnt = 1'b1;
                end
                state_d  = PRI_IF;
                streak_d = '0;
            end
            default: begin
                state_d  = PRI_IF;
                streak_d = '0;
            end
        endcase
    end

    always_comb begin
        granted_addr = '0;
        if (if_gnt) begin
            granted_addr = bus.if_addr;
        end else if (dbg_gnt) begin
            granted_addr = bus.dbg_addr;
        end
    end

    assign bus.if_gnt   = if_gnt;
    assign bus.dbg_gnt  = dbg_gnt;
    assign bus.mem_addr = granted_addr & WORD_MASK;

    always_comb begin
        if_rvalid_d  = if_gnt;
        if_rdata_d   = if_gnt ? bus.mem_rdata : if_rdata_q;
        dbg_rvalid_d = dbg_gnt;
        dbg_rdata_d  = dbg_gnt ? bus.mem_rdata : dbg_rdata_q;
        dbg_err_d    = dbg_gnt && (bus.dbg_addr[1:0] != 2'b00);
    end

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_dbg_q, perf_dbg_d;
    logic [31:0] perf_force_q, perf_force_d;
    logic        force_entry;

    assign force_entry = (state_q == PRI_IF) && (state_d == FORCE_DBG);

    always_comb begin
        perf_if_d    = perf_if_q;
        perf_dbg_d   = perf_dbg_q;
        perf_force_d = perf_force_q;
        if (if_gnt && (perf_if_q != '1)) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (dbg_gnt && (perf_dbg_q != '1)) begin
            perf_dbg_d = perf_dbg_q + 32'd1;
        end
        if (force_entry && (perf_force_q != '1)) begin
            perf_force_d = perf_force_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_q    <= '0;
            perf_dbg_q   <= '0;
            perf_force_q <= '0;
        end else begin
            perf_if_q    <= perf_if_d;
            perf_dbg_q   <= perf_dbg_d;
            perf_force_q <= perf_force_d;
        end
    end

    assign perf_if_cnt    = perf_if_q;
    assign perf_dbg_cnt   = perf_dbg_q;
    assign perf_force_cnt = perf_force_q;
`endif

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRI_IF;
            streak_q     <= '0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            // NOTE: the data registers are reset too because they are visible outputs with defined reset values.
            if_rdata_q   <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            if_rvalid_q  <= if_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_err_q    <= dbg_err_d;
            if_rdata_q   <= if_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: vector table plus hand sequences for reset and perf counters.
module tb_imem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_if_cnt, perf_dbg_cnt, perf_force_cnt;
`endif

    imem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .STREAK_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef IMEM_ARB_PERF_EN
        .perf_if_cnt(perf_if_cnt),
        .perf_dbg_cnt(perf_dbg_cnt),
        .perf_force_cnt(perf_force_cnt),
`endif
        .bus(bus)
    );

    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        return 32'hC0DE_0000 + ({2'b00, idx} * 32'h0001_0101);
    endfunction

    assign bus.mem_rdata = rom_word(bus.mem_addr[31:2]);

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dbg_req;
        logic [31:0] dbg_addr;
        logic        e_if_gnt;
        logic        e_dbg_gnt;
        logic [31:0] e_mem_addr;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_dbg_rvalid;
        logic [31:0] e_dbg_rdata;
        logic        e_dbg_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
        input logic eig, input logic edg, input logic [31:0] em,
        input logic eiv, input logic [31:0] eid,
        input logic edv, input logic [31:0] edd, input logic eerr);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.dbg_req = dr;  v.dbg_addr = da;
        v.e_if_gnt = eig;  v.e_dbg_gnt = edg;  v.e_mem_addr = em;
        v.e_if_rvalid = eiv;  v.e_if_rdata = eid;
        v.e_dbg_rvalid = edv; v.e_dbg_rdata = edd; v.e_dbg_err = eerr;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dbg_req  = dr;
        bus.dbg_addr = da;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        step();
        step();

        // Reset state.
        chk1("rst if_rvalid", bus.if_rvalid, 1'b0);
        chk32("rst if_rdata", bus.if_rdata, 32'h0);
        chk1("rst dbg_rvalid", bus.dbg_rvalid, 1'b0);
        chk32("rst dbg_rdata", bus.dbg_rdata, 32'h0);
        chk1("rst dbg_err", bus.dbg_err, 1'b0);
        reset = 1'b0;

        // Single fetch of word 1.
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h0);
        #3;
        chk1("s1 if_gnt", bus.if_gnt, 1'b1);
        chk1("s1 dbg_gnt", bus.dbg_gnt, 1'b0);
        chk32("s1 mem_addr", bus.mem_addr, 32'h4);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk1("s1 if_rvalid", bus.if_rvalid, 1'b1);
        chk32("s1 if_rdata", bus.if_rdata, rom_word(30'd1));
        chk1("s1 dbg_rvalid", bus.dbg_rvalid, 1'b0);
        chk32("s1 dbg_rdata", bus.dbg_rdata, 32'h0);
        chk1("s1 dbg_err", bus.dbg_err, 1'b0);
        chk32("s1 idle mem_addr", bus.mem_addr, 32'h0);
        step();

        // Forced DBG slot after 4 IF grants.
        vecs.push_back(mk(1, 32'h00, 1, 32'h10, 1, 0, 32'h00, 0, 0,             0, 0,            0));
        vecs.push_back(mk(1, 32'h04, 1, 32'h10, 1, 0, 32'h04, 1, rom_word(0),   0, 0,            0));
        vecs.push_back(mk(1, 32'h08, 1, 32'h10, 1, 0, 32'h08, 1, rom_word(1),   0, 0,            0));
        vecs.push_back(mk(1, 32'h0C, 1, 32'h10, 1, 0, 32'h0C, 1, rom_word(2),   0, 0,            0));
        vecs.push_back(mk(1, 32'h10, 1, 32'h10, 0, 1, 32'h10, 1, rom_word(3),   0, 0,            0));
        vecs.push_back(mk(1, 32'h10, 0, 32'h00, 1, 0, 32'h10, 0, 0,             1, rom_word(4),  0));
        vecs.push_back(mk(0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 1, rom_word(4),   0, 0,            0));
        vecs.push_back(mk(0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 0, 0,             0, 0,            0));
        // Misaligned debug read returns the aligned word with dbg_err.
        vecs.push_back(mk(0, 32'h00, 1, 32'h0A, 0, 1, 32'h08, 0, 0,             0, 0,            0));
        vecs.push_back(mk(0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 0, 0,             1, rom_word(2),  1));
        // Streak reaches 3, dbg_req drops once, then 4 fresh IF grants precede the forced DBG slot.
        vecs.push_back(mk(1, 32'h20, 1, 32'h14, 1, 0, 32'h20, 0, 0,             0, 0,            0));
        vecs.push_back(mk(1, 32'h24, 1, 32'h14, 1, 0, 32'h24, 1, rom_word(8),   0, 0,            0));
        vecs.push_back(mk(1, 32'h28, 1, 32'h14, 1, 0, 32'h28, 1, rom_word(9),   0, 0,            0));
        vecs.push_back(mk(1, 32'h2C, 0, 32'h14, 1, 0, 32'h2C, 1, rom_word(10),  0, 0,            0));
        vecs.push_back(mk(1, 32'h30, 1, 32'h14, 1, 0, 32'h30, 1, rom_word(11),  0, 0,            0));
        vecs.push_back(mk(1, 32'h34, 1, 32'h14, 1, 0, 32'h34, 1, rom_word(12),  0, 0,            0));
        vecs.push_back(mk(1, 32'h38, 1, 32'h14, 1, 0, 32'h38, 1, rom_word(13),  0, 0,            0));
        vecs.push_back(mk(1, 32'h3C, 1, 32'h14, 1, 0, 32'h3C, 1, rom_word(14),  0, 0,            0));
        vecs.push_back(mk(1, 32'h40, 1, 32'h14, 0, 1, 32'h14, 1, rom_word(15),  0, 0,            0));
        vecs.push_back(mk(0, 32'h00, 0, 32'h00, 0, 0, 32'h00, 0, 0,             1, rom_word(5),  0));

        foreach (vecs[i]) begin
            drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].dbg_req, vecs[i].dbg_addr);
            #3;
            chk1($sformatf("v%0d if_gnt", i), bus.if_gnt, vecs[i].e_if_gnt);
            chk1($sformatf("v%0d dbg_gnt", i), bus.dbg_gnt, vecs[i].e_dbg_gnt);
            chk32($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].e_mem_addr);
            chk1($sformatf("v%0d if_rvalid", i), bus.if_rvalid, vecs[i].e_if_rvalid);
            chk1($sformatf("v%0d dbg_rvalid", i), bus.dbg_rvalid, vecs[i].e_dbg_rvalid);
            chk1($sformatf("v%0d dbg_err", i), bus.dbg_err, vecs[i].e_dbg_err);
            if (vecs[i].e_if_rvalid) begin
                chk32($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].e_if_rdata);
            end
            if (vecs[i].e_dbg_rvalid) begin
                chk32($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata, vecs[i].e_dbg_rdata);
            end
            step();
        end

        // Reset right behind an accepted fetch drops its response.
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0);
        #3;
        chk1("rm if_gnt", bus.if_gnt, 1'b1);
        reset = 1'b1;
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk1("rm if_rvalid n+1", bus.if_rvalid, 1'b0);
        step();
        chk1("rm if_rvalid n+2", bus.if_rvalid, 1'b0);
        chk32("rm if_rdata", bus.if_rdata, 32'h0);
        chk32("rm dbg_rdata", bus.dbg_rdata, 32'h0);
        chk1("rm dbg_rvalid", bus.dbg_rvalid, 1'b0);
        chk1("rm dbg_err", bus.dbg_err, 1'b0);
        reset = 1'b0;
        step();
        chk1("rm post if_rvalid", bus.if_rvalid, 1'b0);

`ifdef IMEM_ARB_PERF_EN
        do_reset();
        chk32("perf rst if", perf_if_cnt, 32'd0);
        begin
            logic [31:0] pc;
            pc = 32'h0;
            for (int c = 0; c < 10; c++) begin
                drive(1'b1, pc, 1'b1, 32'h10);
                #3;
                if (bus.if_gnt) pc = pc + 32'd4;
                step();
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk32("perf if_cnt", perf_if_cnt, 32'd8);
        chk32("perf dbg_cnt", perf_dbg_cnt, 32'd2);
        chk32("perf force_cnt", perf_force_cnt, 32'd2);
`else
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
